// File: rtl/dm_io_pkg.sv
// dm_io_pkg: shared definitions for the data-memory / I/O unit.
//   - funct3 load/store size codes
//   - FSM state encoding (plain localparams for legacy tools)
//   - lane helpers: load extract/extend, store byte-enable/shift, request legality
package dm_io_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DM   = 2'd1;
    localparam logic [1:0] ST_IO   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } wr_lane_t;

    // Pull the addressed byte/half lane down to bit 0 and extend it per mode.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  mode);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (mode)
            MODE_B:  return {{24{sh[7]}}, sh[7:0]};
            MODE_BU: return {24'h000000, sh[7:0]};
            MODE_H:  return {{16{sh[15]}}, sh[15:0]};
            MODE_HU: return {16'h0000, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Right-aligned store data moved into its lane, with matching byte enables.
    function automatic wr_lane_t store_lanes(input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  mode);
        wr_lane_t r;
        r.data = wdata << {lane, 3'b000};
        case (mode[1:0])
            2'b00:   r.be = 4'b0001 << lane;
            2'b01:   r.be = 4'b0011 << lane;
            default: r.be = 4'b1111;
        endcase
        return r;
    endfunction

    // Illegal size code or misaligned address: the request completes with err.
    function automatic logic access_bad(input logic       we,
                                        input logic [2:0] mode,
                                        input logic [1:0] lane);
        logic illegal;
        logic misal;
        if (we) begin
            illegal = (mode > MODE_W);
        end else begin
            illegal = (mode == 3'b011) || (mode == 3'b110) || (mode == 3'b111);
        end
        misal = ((mode[1:0] == 2'b01) && lane[0]) ||
                ((mode[1:0] == 2'b10) && (lane != 2'b00));
        return illegal || misal;
    endfunction

endpackage

// File: rtl/dm_io_ram.sv
// dm_io_ram: DEPTH x 32 synchronous RAM.
//   Port A: enable, 4-bit byte-enable write and registered read of the old word.
//   Port B: read-only, registered, returns the low BW bits; reset clears only
//           the output register, never the array.
// Ports: clk_i, rst_ni, a_en_i, a_be_i, a_addr_i, a_wdata_i, a_rdata_o,
//        b_addr_i, b_rdata_o.
module dm_io_ram
    import dm_io_pkg::*;
#(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned BW    = 12,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          a_en_i,
    input  logic [3:0]    a_be_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    input  logic [AW-1:0] b_addr_i,
    output logic [BW-1:0] b_rdata_o
);

    logic [31:0] mem [DEPTH];

    // Writes are suppressed while reset is held so an edge during reset cannot
    // commit a store the FSM never accepted.
    always_ff @(posedge clk_i) begin
        if (a_en_i && rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be_i[i]) begin
                    mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
                end
            end
            a_rdata_o <= mem[a_addr_i];
        end
    end

    // Non-blocking array writes mean a same-edge store is seen as old data here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_rdata_o <= '0;
        end else begin
            b_rdata_o <= mem[b_addr_i][BW-1:0];
        end
    end

endmodule

// File: rtl/dm_io_unit.sv
// dm_io_unit: MEM-stage data access unit for RV32 loads/stores.
//   req_i/we_i/mode_i/addr_i/wdata_i : request, sampled only while idle
//   rdata_o/done_o/err_o/busy_o      : one-cycle completion with extended data
//   io_*                             : memory-mapped I/O bus, strobes held to ack
//   scr_addr_i/scr_data_o            : independent registered screen read port
// RAM accesses finish the cycle after acceptance (state DM drives done); errors
// and I/O completions go through RESP. Every done is followed by IDLE, so the
// unit accepts at most one access every two cycles.
module dm_io_unit
    import dm_io_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_DEPTH   = 16384,
    parameter logic [15:0] IO_BASE    = 16'hFFFF,
    parameter int unsigned IO_TIMEOUT = 255,
    parameter int unsigned SCR_AW     = 15,
    parameter int unsigned SCR_DW     = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        mode_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [15:0]       io_addr_o,
    output logic [DATA_W-1:0] io_wdata_o,
    output logic              io_we_o,
    output logic              io_rd_o,
    input  logic [DATA_W-1:0] io_rdata_i,
    input  logic              io_ack_i,
    input  logic [SCR_AW-1:0] scr_addr_i,
    output logic [SCR_DW-1:0] scr_data_o
);

    localparam int unsigned AW    = $clog2(DM_DEPTH);
    localparam int unsigned CNT_W = $clog2(IO_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        lane_q, lane_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              io_rd_q, io_rd_d;
    logic              io_we_q, io_we_d;
    logic [15:0]       io_addr_q, io_addr_d;
    logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic          accept;
    logic          io_hit;
    logic          bad;
    wr_lane_t      lanes;
    logic          ram_en;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;
    logic [AW-1:0] scr_idx;
    logic [SCR_AW+AW-1:0] scr_wide;
    logic          unused_scr;

    assign accept = (state_q == ST_IDLE) && req_i;
    assign io_hit = (addr_i[31:16] == IO_BASE);
    assign bad    = access_bad(we_i, mode_i, addr_i[1:0]);
    assign lanes  = store_lanes(wdata_i, addr_i[1:0], mode_i);
    assign ram_en = accept && !bad && !io_hit;
    assign ram_be = we_i ? lanes.be : 4'b0000;

    // Screen address is fitted to the RAM index width (truncate or zero-extend).
    assign scr_wide   = {{AW{1'b0}}, scr_addr_i};
    assign scr_idx    = scr_wide[AW-1:0];
    assign unused_scr = ^scr_wide[SCR_AW+AW-1:AW];

    dm_io_ram #(
        .DEPTH (DM_DEPTH),
        .BW    (SCR_DW)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .a_en_i    (ram_en),
        .a_be_i    (ram_be),
        .a_addr_i  (addr_i[AW+1:2]),
        .a_wdata_i (lanes.data),
        .a_rdata_o (ram_rdata),
        .b_addr_i  (scr_idx),
        .b_rdata_o (scr_data_o)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        mode_d     = mode_q;
        lane_d     = lane_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        io_rd_d    = io_rd_q;
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    mode_d  = mode_i;
                    lane_d  = addr_i[1:0];
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (io_hit) begin
                        io_rd_d    = !we_i;
                        io_we_d    = we_i;
                        io_addr_d  = addr_i[15:0];
                        io_wdata_d = wdata_i;
                        cnt_d      = '0;
                        state_d    = ST_IO;
                    end else begin
                        state_d = ST_DM;
                    end
                end
            end
            ST_DM: begin
                state_d = ST_IDLE;
            end
            ST_IO: begin
                // An ack on the final allowed cycle still counts as success.
                if (io_ack_i) begin
                    io_rd_d = 1'b0;
                    io_we_d = 1'b0;
                    rdata_d = we_q ? '0 : load_extend(io_rdata_i, lane_q, mode_q);
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(IO_TIMEOUT - 1)) begin
                    io_rd_d = 1'b0;
                    io_we_d = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            mode_q     <= 3'b000;
            lane_q     <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            io_rd_q    <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            mode_q     <= mode_d;
            lane_q     <= lane_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            io_rd_q    <= io_rd_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            cnt_q      <= cnt_d;
        end
    end

    // RAM load data comes straight off the synchronous read in the DM cycle.
    always_comb begin
        rdata_o = '0;
        if (state_q == ST_DM && !we_q) begin
            rdata_o = load_extend(ram_rdata, lane_q, mode_q);
        end else if (state_q == ST_RESP) begin
            rdata_o = rdata_q;
        end
    end

    assign done_o     = (state_q == ST_DM) || (state_q == ST_RESP);
    assign err_o      = (state_q == ST_RESP) && err_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign io_rd_o    = io_rd_q;
    assign io_we_o    = io_we_q;
    assign io_addr_o  = io_addr_q;
    assign io_wdata_o = io_wdata_q;

endmodule

// File: tb/tb_dm_io_unit.sv
module tb_dm_io_unit;

    localparam int unsigned DM_DEPTH = 16384;
    localparam int unsigned MEMB     = DM_DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [2:0]  mode;
    logic [31:0] addr, wdata, rdata;
    logic        done, err, busy;
    logic [15:0] io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic        io_we, io_rd, io_ack;
    logic [14:0] scr_addr;
    logic [11:0] scr_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_io_unit dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .we_i       (we),
        .mode_i     (mode),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .done_o     (done),
        .err_o      (err),
        .busy_o     (busy),
        .io_addr_o  (io_addr),
        .io_wdata_o (io_wdata),
        .io_we_o    (io_we),
        .io_rd_o    (io_rd),
        .io_rdata_i (io_rdata),
        .io_ack_i   (io_ack),
        .scr_addr_i (scr_addr),
        .scr_data_o (scr_data)
    );

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] mbytes [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: access size in bytes, legality and extension from the funct3 rules.
    function automatic int size_of(input logic [2:0] m);
        if (m[1:0] == 2'b00) return 1;
        if (m[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_bad(input logic w, input logic [2:0] m, input logic [31:0] a);
        bit illegal;
        illegal = w ? (m > 3'd2) : (m == 3'd3 || m == 3'd6 || m == 3'd7);
        return illegal || ((a % size_of(m)) != 0);
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] raw, input logic [2:0] m);
        int bits;
        logic [31:0] v;
        bits = 8 * size_of(m);
        if (bits == 32) return raw;
        v = raw & ~(32'hFFFF_FFFF << bits);
        if (!m[2] && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    function automatic logic [31:0] model_ram_load(input logic [31:0] a, input logic [2:0] m);
        logic [31:0] raw = 32'h0;
        for (int i = 0; i < size_of(m); i++) begin
            raw = raw | (32'(mbytes[int'((a + i) % MEMB)]) << (8 * i));
        end
        return model_ext(raw, m);
    endfunction

    task automatic model_ram_store(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
        for (int i = 0; i < size_of(m); i++) begin
            mbytes[int'((a + i) % MEMB)] = d[8*i +: 8];
        end
    endtask

    // Issue one request and follow it to done (bounded). ack_after=0 never acks.
    task automatic run_access(input logic w, input logic [2:0] m, input logic [31:0] a,
                              input logic [31:0] d, input int ack_after,
                              input logic [31:0] ack_data, output logic [31:0] rd,
                              output logic e, output int lat, output int strobes,
                              output logic io_bad, output logic done_again);
        @(negedge clk);
        req = 1'b1; we = w; mode = m; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1; strobes = 0; io_bad = 1'b0;
        while (done !== 1'b1 && lat < 400) begin
            if (io_rd || io_we) begin
                strobes++;
                if (io_addr !== a[15:0] || io_we !== w || io_rd !== !w) io_bad = 1'b1;
                if (w && io_wdata !== d) io_bad = 1'b1;
                if (ack_after != 0 && strobes == ack_after) begin
                    io_ack = 1'b1;
                    io_rdata = ack_data;
                end
            end
            @(posedge clk); #1;
            io_ack = 1'b0;
            lat++;
        end
        rd = rdata;
        e = err;
        @(posedge clk); #1;
        done_again = done;
    endtask

    logic [31:0] rd, exp_v, ad, dd, ackd;
    logic        e, iob, dag, w;
    logic [2:0]  m;
    int          lat, stb, ackn, dcount;
    bit          is_io, bad;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; mode = 3'b0; addr = 32'h0; wdata = 32'h0;
        io_rdata = 32'h0; io_ack = 1'b0; scr_addr = 15'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_io_we", {31'b0, io_we}, 0);
        check("rst_io_rd", {31'b0, io_rd}, 0);
        check("rst_io_addr", {16'b0, io_addr}, 0);
        check("rst_io_wdata", io_wdata, 0);
        check("rst_scr_data", {20'b0, scr_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of directed RAM vectors
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h0000_0103, 32'h1234_5680, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'h80AD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h0000_0101, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'h80AD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd6, 32'h0000_0100, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd7, 32'h0000_0100, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'd1, 32'h0000_0102, 32'hAAAA_8001, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'hFFFF_8001, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h0000_0102, 32'h0,         32'h0000_8001, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0102, 32'h1111_1111, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 3'd4, 32'h0000_0100, 32'h2222_2222, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'h8001_BEEF, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h0000_0101, 32'h0,         32'hFFFF_FFBE, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h0000_0100, 32'h0,         32'h0000_00EF, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h0000_0100, 32'h0,         32'h0000_BEEF, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0001_0020, 32'h1357_9BDF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h0000_0020, 32'h0,         32'h1357_9BDF, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'hFFFE_0020, 32'h0,         32'h1357_9BDF, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h0000_0200, 32'h1111_2222, 32'h0, 1'b0});

        foreach (vecs[i]) begin
            run_access(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata, 0, 32'h0,
                       rd, e, lat, stb, iob, dag);
            check($sformatf("vec%0d_latency", i), lat, 1);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            if (!vecs[i].we || vecs[i].exp_err) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_done_single", i), {31'b0, dag}, 0);
        end

        // I/O read with ack in the third strobe cycle; a request while busy is dropped
        @(negedge clk);
        req = 1'b1; we = 1'b0; mode = 3'd2; addr = 32'hFFFF_0010;
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h0000_0200; wdata = 32'hCAFE_F00D;
        check("io_rd_c1", {31'b0, io_rd}, 1);
        check("io_we_c1", {31'b0, io_we}, 0);
        check("io_addr_c1", {16'b0, io_addr}, 32'h10);
        check("io_busy_c1", {31'b0, busy}, 1);
        @(posedge clk); #1;
        check("io_rd_c2", {31'b0, io_rd}, 1);
        check("io_addr_c2", {16'b0, io_addr}, 32'h10);
        check("io_done_c2", {31'b0, done}, 0);
        @(posedge clk); #1;
        check("io_rd_c3", {31'b0, io_rd}, 1);
        req = 1'b0; io_ack = 1'b1; io_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        io_ack = 1'b0;
        check("io_rd_after_ack", {31'b0, io_rd}, 0);
        check("io_done", {31'b0, done}, 1);
        check("io_err", {31'b0, err}, 0);
        check("io_rdata", rdata, 32'h1234_5678);
        @(posedge clk); #1;
        check("io_done_drop", {31'b0, done}, 0);
        check("io_busy_drop", {31'b0, busy}, 0);
        // Stray ack while idle
        io_ack = 1'b1;
        @(posedge clk); #1;
        io_ack = 1'b0;
        check("stray_ack_done", {31'b0, done}, 0);
        check("stray_ack_busy", {31'b0, busy}, 0);
        run_access(1'b0, 3'd2, 32'h0000_0200, 32'h0, 0, 32'h0, rd, e, lat, stb, iob, dag);
        check("busy_req_ignored", rd, 32'h1111_2222);

        // I/O store that never acks: timeout
        run_access(1'b1, 3'd2, 32'hFFFF_0020, 32'h55AA_55AA, 0, 32'h0, rd, e, lat, stb, iob, dag);
        check("to_strobe_cycles", stb, 255);
        check("to_latency", lat, 256);
        check("to_err", {31'b0, e}, 1);
        check("to_rdata", rd, 0);
        check("to_bus_stable", {31'b0, iob}, 0);
        check("to_done_single", {31'b0, dag}, 0);

        // Reset during an I/O wait
        @(negedge clk);
        req = 1'b1; we = 1'b1; mode = 3'd2; addr = 32'hFFFF_0024; wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_we_before", {31'b0, io_we}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_we_drop", {31'b0, io_we}, 0);
        check("rstmid_busy", {31'b0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done || io_we) dcount++;
        end
        check("rstmid_no_done", dcount, 0);

        // Screen port: same-edge read returns old data, new data one cycle later
        scr_addr = 15'd5;
        run_access(1'b1, 3'd2, 32'h0000_0014, 32'h0000_0123, 0, 32'h0, rd, e, lat, stb, iob, dag);
        @(negedge clk);
        req = 1'b1; we = 1'b1; mode = 3'd2; addr = 32'h0000_0014; wdata = 32'h0000_0ABC;
        @(posedge clk); #1;
        req = 1'b0;
        check("scr_same_edge_old", {20'b0, scr_data}, 32'h123);
        @(posedge clk); #1;
        check("scr_new", {20'b0, scr_data}, 32'hABC);
        run_access(1'b1, 3'd0, 32'h0000_0015, 32'h0000_005F, 0, 32'h0, rd, e, lat, stb, iob, dag);
        check("scr_byte_lane", {20'b0, scr_data}, 32'hFBC);

        // Randomised traffic against the byte-array reference
        for (int i = 0; i < 64; i++) begin
            dd = $urandom;
            ad = 32'h400 + 32'(4 * i);
            run_access(1'b1, 3'd2, ad, dd, 0, 32'h0, rd, e, lat, stb, iob, dag);
            model_ram_store(ad, 3'd2, dd);
        end
        for (int i = 0; i < 150; i++) begin
            is_io = ($urandom_range(0, 4) == 0);
            m     = 3'($urandom_range(0, 7));
            w     = 1'($urandom_range(0, 1));
            ad    = is_io ? {16'hFFFF, 8'h00, 8'($urandom)} : 32'h400 + 32'($urandom_range(0, 255));
            dd    = $urandom;
            ackd  = $urandom;
            ackn  = $urandom_range(1, 4);
            bad   = model_bad(w, m, ad);
            run_access(w, m, ad, dd, ackn, ackd, rd, e, lat, stb, iob, dag);
            check($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, bad});
            check($sformatf("rnd%0d_done_single", i), {31'b0, dag}, 0);
            if (bad) begin
                check($sformatf("rnd%0d_latency", i), lat, 1);
                check($sformatf("rnd%0d_rdata", i), rd, 0);
            end else if (is_io) begin
                check($sformatf("rnd%0d_io_latency", i), lat, ackn + 1);
                check($sformatf("rnd%0d_io_bus", i), {31'b0, iob}, 0);
                if (!w) begin
                    exp_v = model_ext(ackd >> (8 * (ad % 4)), m);
                    check($sformatf("rnd%0d_io_rdata", i), rd, exp_v);
                end
            end else begin
                check($sformatf("rnd%0d_latency", i), lat, 1);
                check($sformatf("rnd%0d_strobes", i), stb, 0);
                if (w) begin
                    model_ram_store(ad, m, dd);
                end else begin
                    exp_v = model_ram_load(ad, m);
                    check($sformatf("rnd%0d_rdata", i), rd, exp_v);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
